rule_packer_128_512: RTL and testbench

RULE_PACKER_128_512 -- requirements
Module: rule_packer_128_512

---
 rtl/rule_packer_128_512.sv | 237 +++++++++++++++++++++++
 tb/tb_rule_packer_128_512.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule_packer_128_512.sv
`default_nettype none
// ============================================================================
//  Module      : rule_packer_128_512
//  Description : Packs nonzero 128-bit rule words into 512-bit beats, lane 0
//                first. Unused lanes are zero-filled. Every rule set (closed
//                by an eop word) ends with one all-zero terminator beat that
//                has eop=1. Zero-valued rule words are dropped.
//
//  Ports
//    clk            : single clock, all state on the rising edge
//    rst_n          : asynchronous active-low reset
//    in_rule_sop    : ignored (set boundaries come from eop only)
//    in_rule_eop    : terminator word of a rule set (its data is ignored)
//    in_rule_valid  : input word valid
//    in_rule_data   : one 128-bit rule entry
//    in_rule_empty  : ignored
//    in_rule_ready  : word accepted when valid & ready on a clock edge
//    out_rule_sop   : first beat of an output packet
//    out_rule_eop   : terminator beat
//    out_rule_valid : output beat valid
//    out_rule_data  : four 128-bit lanes, lane k = bits [128k+127:128k]
//    out_rule_empty : 16 x unused lanes on data beats, 0 on the terminator
//    out_rule_ready : downstream accept
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rule_packer_128_512 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_rule_sop,
  input  logic         in_rule_eop,
  input  logic         in_rule_valid,
  input  logic [127:0] in_rule_data,
  input  logic [3:0]   in_rule_empty,
  output logic         in_rule_ready,
  output logic         out_rule_sop,
  output logic         out_rule_eop,
  output logic         out_rule_valid,
  output logic [511:0] out_rule_data,
  output logic [5:0]   out_rule_empty,
  input  logic         out_rule_ready
);

  localparam int C_LANES  = 4;
  localparam int C_LANE_W = 128;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    TERM = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t         r_state;
  state_t         w_state_nxt;
  logic [511:0]   r_acc;
  logic [511:0]   w_acc_nxt;
  logic [1:0]     r_lane_cnt;
  logic [1:0]     w_lane_cnt_nxt;
  logic           r_first;
  logic           w_first_nxt;

  logic           r_out_valid;
  logic           r_out_sop;
  logic           r_out_eop;
  logic [511:0]   r_out_data;
  logic [5:0]     r_out_empty;
  logic           w_out_valid_nxt;
  logic           w_out_sop_nxt;
  logic           w_out_eop_nxt;
  logic [511:0]   w_out_data_nxt;
  logic [5:0]     w_out_empty_nxt;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic           w_out_free;
  logic           w_accept;
  logic           w_word_nz;
  logic           w_write_lane;
  logic [C_LANES-1:0] w_lane_we;
  logic [5:0]     w_flush_empty;

  // sop and the input empty field carry no information for this block.
  logic           w_unused;
  assign w_unused = ^{in_rule_sop, in_rule_empty};

  assign w_out_free    = !r_out_valid || out_rule_ready;
  assign in_rule_ready = (r_state == FILL) && w_out_free;
  assign w_accept      = in_rule_valid && in_rule_ready;
  assign w_word_nz     = |in_rule_data;

  // A nonzero word lands in the accumulator only for lanes 0..2; the word
  // that would fill lane 3 goes straight into the output register instead.
  assign w_write_lane  = w_accept && !in_rule_eop && w_word_nz && (r_lane_cnt != 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < C_LANES; gi++) begin : g_lane
      assign w_lane_we[gi] = w_write_lane && (r_lane_cnt == 2'(gi));
    end
  endgenerate

  // Empty count for a partial flush: 16 per unused lane.
  always_comb begin
    w_flush_empty = 6'd0;
    case (r_lane_cnt)
      2'd1:    w_flush_empty = 6'd48;
      2'd2:    w_flush_empty = 6'd32;
      2'd3:    w_flush_empty = 6'd16;
      default: w_flush_empty = 6'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state / output-register logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_lane_cnt_nxt  = r_lane_cnt;
    w_first_nxt     = r_first;
    w_out_valid_nxt = r_out_valid;
    w_out_sop_nxt   = r_out_sop;
    w_out_eop_nxt   = r_out_eop;
    w_out_data_nxt  = r_out_data;
    w_out_empty_nxt = r_out_empty;

    // The current beat leaves (or there was none): drop valid unless a new
    // beat is loaded below. Fields stay put while the beat is stalled.
    if (w_out_free) begin
      w_out_valid_nxt = 1'b0;
    end

    for (int k = 0; k < C_LANES; k++) begin
      if (w_lane_we[k]) begin
        w_acc_nxt[k*C_LANE_W +: C_LANE_W] = in_rule_data;
      end
    end

    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (!in_rule_eop) begin
            if (w_word_nz) begin
              if (r_lane_cnt == 2'd3) begin
                w_out_valid_nxt = 1'b1;
                w_out_sop_nxt   = r_first;
                w_out_eop_nxt   = 1'b0;
                w_out_data_nxt  = {in_rule_data, r_acc[383:0]};
                w_out_empty_nxt = 6'd0;
                w_acc_nxt       = '0;
                w_lane_cnt_nxt  = 2'd0;
                w_first_nxt     = 1'b0;
              end else begin
                w_lane_cnt_nxt  = r_lane_cnt + 2'd1;
              end
            end
          end else if (r_lane_cnt != 2'd0) begin
            // Partial beat first; the terminator follows from TERM once
            // this flush beat has been taken.
            w_out_valid_nxt = 1'b1;
            w_out_sop_nxt   = r_first;
            w_out_eop_nxt   = 1'b0;
            w_out_data_nxt  = r_acc;
            w_out_empty_nxt = w_flush_empty;
            w_acc_nxt       = '0;
            w_lane_cnt_nxt  = 2'd0;
            w_first_nxt     = 1'b0;
            w_state_nxt     = TERM;
          end else begin
            // Nothing buffered: the terminator goes out directly. sop is set
            // when the whole set was empty.
            w_out_valid_nxt = 1'b1;
            w_out_sop_nxt   = r_first;
            w_out_eop_nxt   = 1'b1;
            w_out_data_nxt  = '0;
            w_out_empty_nxt = 6'd0;
            w_first_nxt     = 1'b1;
          end
        end
      end

      TERM: begin
        if (w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_sop_nxt   = 1'b0;
          w_out_eop_nxt   = 1'b1;
          w_out_data_nxt  = '0;
          w_out_empty_nxt = 6'd0;
          w_first_nxt     = 1'b1;
          w_state_nxt     = FILL;
        end
      end

      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_acc       <= '0;
      r_lane_cnt  <= 2'd0;
      r_first     <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_data  <= '0;
      r_out_empty <= 6'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_lane_cnt  <= w_lane_cnt_nxt;
      r_first     <= w_first_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_sop   <= w_out_sop_nxt;
      r_out_eop   <= w_out_eop_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_empty <= w_out_empty_nxt;
    end
  end

  assign out_rule_valid = r_out_valid;
  assign out_rule_sop   = r_out_sop;
  assign out_rule_eop   = r_out_eop;
  assign out_rule_data  = r_out_data;
  assign out_rule_empty = r_out_empty;

endmodule
`default_nettype wire

// File: tb/tb_rule_packer_128_512.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rule_packer_128_512
//  Description : Self-checking bench for rule_packer_128_512. A queue-based
//                model turns accepted input words into expected beats; every
//                accepted output beat is compared against it, stalled beats
//                must stay stable, and directed sets are pinned to literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rule_packer_128_512;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic [5:0]   empty;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic         in_rule_sop;
  logic         in_rule_eop;
  logic         in_rule_valid;
  logic [127:0] in_rule_data;
  logic [3:0]   in_rule_empty;
  logic         in_rule_ready;
  logic         out_rule_sop;
  logic         out_rule_eop;
  logic         out_rule_valid;
  logic [511:0] out_rule_data;
  logic [5:0]   out_rule_empty;
  logic         out_rule_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  beat_t        exp_q[$];
  beat_t        got[$];
  logic [127:0] m_words[$];
  bit           m_first = 1'b1;
  bit           held_v  = 1'b0;
  beat_t        held_beat;

  rule_packer_128_512 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_rule_sop    (in_rule_sop),
    .in_rule_eop    (in_rule_eop),
    .in_rule_valid  (in_rule_valid),
    .in_rule_data   (in_rule_data),
    .in_rule_empty  (in_rule_empty),
    .in_rule_ready  (in_rule_ready),
    .out_rule_sop   (out_rule_sop),
    .out_rule_eop   (out_rule_eop),
    .out_rule_valid (out_rule_valid),
    .out_rule_data  (out_rule_data),
    .out_rule_empty (out_rule_empty),
    .out_rule_ready (out_rule_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: collect nonzero words of the current set; four make a full beat,
  // eop flushes any remainder and then appends the terminator.
  task automatic model_emit();
    beat_t b;
    int    n;
    n       = m_words.size();
    b.data  = '0;
    for (int i = 0; i < n; i++) b.data[i*128 +: 128] = m_words[i];
    b.sop   = m_first;
    b.eop   = 1'b0;
    b.empty = 6'(16 * (4 - n));
    exp_q.push_back(b);
    m_words.delete();
    m_first = 1'b0;
  endtask

  task automatic model_accept(input logic [127:0] d, input logic e);
    beat_t t;
    if (!e) begin
      if (d != '0) begin
        m_words.push_back(d);
        if (m_words.size() == 4) model_emit();
      end
    end else begin
      if (m_words.size() > 0) model_emit();
      t.data  = '0;
      t.sop   = m_first;
      t.eop   = 1'b1;
      t.empty = 6'd0;
      exp_q.push_back(t);
      m_first = 1'b1;
    end
  endtask

  // Compare process: sampled on the falling edge, which sees the values that
  // the next rising edge will act on.
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = '{data: out_rule_data, sop: out_rule_sop, eop: out_rule_eop, empty: out_rule_empty};
    if (!rst_n) begin
      exp_q.delete();
      m_words.delete();
      m_first = 1'b1;
      held_v  = 1'b0;
    end else begin
      if (out_rule_valid) begin
        if (held_v) begin
          n_chk++;
          if (cur !== held_beat) begin
            n_fail++;
            $display("FAIL hold_stable: got sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                     cur.sop, cur.eop, cur.empty, cur.data, held_beat.sop, held_beat.eop, held_beat.empty, held_beat.data);
          end
        end
        if (!out_rule_ready) begin
          n_chk++;
          if (in_rule_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL in_ready_backpressure: got %b, required 0", in_rule_ready);
          end
          held_v    = 1'b1;
          held_beat = cur;
        end else begin
          held_v = 1'b0;
          got.push_back(cur);
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got sop=%b eop=%b empty=%0d data=%h, required no beat",
                     cur.sop, cur.eop, cur.empty, cur.data);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL beat_model: got sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
                       cur.sop, cur.eop, cur.empty, cur.data, e.sop, e.eop, e.empty, e.data);
            end
          end
        end
      end else begin
        held_v = 1'b0;
      end
      if (in_rule_valid && in_rule_ready) model_accept(in_rule_data, in_rule_eop);
    end
  end

  // Offer one word and hold it until accepted (bounded).
  task automatic send(input logic [127:0] d, input logic e);
    in_rule_valid = 1'b1;
    in_rule_data  = e ? 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D : d;
    in_rule_eop   = e;
    in_rule_sop   = 1'($urandom_range(0, 1));
    in_rule_empty = 4'($urandom_range(0, 15));
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_rule_ready) begin
        @(posedge clk);
        #1;
        in_rule_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: got no accept in 200 cycles, required accept");
    in_rule_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !out_rule_valid) break;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (exp_q.size() != 0 || out_rule_valid) begin
      n_fail++;
      $display("FAIL drain_%s: got %0d beats outstanding valid=%b, required 0 and 0", nm, exp_q.size(), out_rule_valid);
    end
  endtask

  task automatic pin(input string nm, input int idx, input logic [511:0] d,
                     input logic s, input logic e, input logic [5:0] emp);
    n_chk++;
    if (idx >= got.size()) begin
      n_fail++;
      $display("FAIL %s: got only %0d beats, required beat %0d", nm, got.size(), idx);
    end else if (got[idx].data !== d || got[idx].sop !== s || got[idx].eop !== e || got[idx].empty !== emp) begin
      n_fail++;
      $display("FAIL %s: got sop=%b eop=%b empty=%0d data=%h, required sop=%b eop=%b empty=%0d data=%h",
               nm, got[idx].sop, got[idx].eop, got[idx].empty, got[idx].data, s, e, emp, d);
    end
  endtask

  task automatic pin_count(input string nm, input int n);
    n_chk++;
    if (got.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d beats, required %0d", nm, got.size(), n);
    end
  endtask

  initial begin
    int c0;
    logic [11:0] pat;
    rst_n          = 1'b0;
    in_rule_sop    = 1'b0;
    in_rule_eop    = 1'b0;
    in_rule_valid  = 1'b0;
    in_rule_data   = '0;
    in_rule_empty  = '0;
    out_rule_ready = 1'b1;

    // Reset state
    #1;
    n_chk++;
    if (out_rule_valid !== 1'b0 || out_rule_sop !== 1'b0 || out_rule_eop !== 1'b0 ||
        out_rule_data !== '0 || out_rule_empty !== 6'd0 || in_rule_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b sop=%b eop=%b empty=%0d in_ready=%b, required 0 0 0 0 1",
               out_rule_valid, out_rule_sop, out_rule_eop, out_rule_empty, in_rule_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Four words then eop, full throughput
    got.delete();
    c0 = cyc;
    send(128'd1, 1'b0); send(128'd2, 1'b0); send(128'd3, 1'b0); send(128'd4, 1'b0);
    send(128'd0, 1'b1);
    n_chk++;
    if (cyc - c0 != 5) begin
      n_fail++;
      $display("FAIL throughput: got %0d cycles for 5 words, required 5", cyc - c0);
    end
    drain("t1");
    pin_count("t1", 2);
    pin("t1_beat", 0, {128'd4, 128'd3, 128'd2, 128'd1}, 1'b1, 1'b0, 6'd0);
    pin("t1_term", 1, 512'd0, 1'b0, 1'b1, 6'd0);

    // Two words then eop: flush beat the cycle after eop, then terminator
    got.delete();
    send(128'd5, 1'b0); send(128'd6, 1'b0); send(128'd0, 1'b1);
    n_chk++;
    if (out_rule_valid !== 1'b1 || out_rule_eop !== 1'b0 || out_rule_empty !== 6'd32) begin
      n_fail++;
      $display("FAIL flush_latency: got valid=%b eop=%b empty=%0d, required 1 0 32",
               out_rule_valid, out_rule_eop, out_rule_empty);
    end
    drain("t2");
    pin_count("t2", 2);
    pin("t2_flush", 0, {128'd0, 128'd0, 128'd6, 128'd5}, 1'b1, 1'b0, 6'd32);
    pin("t2_term", 1, 512'd0, 1'b0, 1'b1, 6'd0);

    // Eop only
    got.delete();
    send(128'd0, 1'b1);
    drain("t3");
    pin_count("t3", 1);
    pin("t3_term", 0, 512'd0, 1'b1, 1'b1, 6'd0);

    // Zero word dropped
    got.delete();
    send(128'd7, 1'b0); send(128'd0, 1'b0); send(128'd8, 1'b0); send(128'd0, 1'b1);
    drain("t4");
    pin_count("t4", 2);
    pin("t4_flush", 0, {128'd0, 128'd0, 128'd8, 128'd7}, 1'b1, 1'b0, 6'd32);

    // Backpressure: ready low for 5 cycles while 8 words are offered
    got.delete();
    out_rule_ready = 1'b0;
    fork
      begin
        for (int i = 11; i <= 18; i++) send(128'(i), 1'b0);
        send(128'd0, 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_rule_ready = 1'b1;
      end
    join
    drain("t5");
    pin_count("t5", 3);
    pin("t5_beat0", 0, {128'd14, 128'd13, 128'd12, 128'd11}, 1'b1, 1'b0, 6'd0);
    pin("t5_beat1", 1, {128'd18, 128'd17, 128'd16, 128'd15}, 1'b0, 1'b0, 6'd0);
    pin("t5_term", 2, 512'd0, 1'b0, 1'b1, 6'd0);

    // Stalled flush beat and terminator with a toggling ready
    got.delete();
    pat = 12'b1011_0010_0110;
    fork
      begin
        send(128'd21, 1'b0); send(128'd22, 1'b0); send(128'd23, 1'b0); send(128'd0, 1'b1);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          out_rule_ready = pat[i];
          @(posedge clk);
          #1;
        end
        out_rule_ready = 1'b1;
      end
    join
    drain("t6");
    pin_count("t6", 2);
    pin("t6_flush", 0, {128'd0, 128'd23, 128'd22, 128'd21}, 1'b1, 1'b0, 6'd16);
    pin("t6_term", 1, 512'd0, 1'b0, 1'b1, 6'd0);

    // Reset mid-set discards the partial accumulator
    got.delete();
    send(128'hAAAA, 1'b0); send(128'hBBBB, 1'b0);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_rule_valid !== 1'b0 || in_rule_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b in_ready=%b, required 0 1", out_rule_valid, in_rule_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(128'd9, 1'b0); send(128'd0, 1'b1);
    drain("t7");
    pin_count("t7", 2);
    pin("t7_flush", 0, {128'd0, 128'd0, 128'd0, 128'd9}, 1'b1, 1'b0, 6'd48);
    pin("t7_term", 1, 512'd0, 1'b0, 1'b1, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
